tpu_command_queue: RTL and testbench
====================================

# tpu_command_queue

Buffers 48-bit TPU commands produced by the I2C register stage and dispatches them, one at a time, to the text-processing unit (TPU). It sits directly downstream of the I2C register block and consumes its `execute`/`command` pair. It returns an almost-full `busy` to that block so that a fast I2C master can post bursts of commands while a slow TPU command (e.g. clear screen) is running. It owns the TPU-side execute/busy handshake.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥ 4.
- `CMD_W`, 48: command width; byte 0 is the TPU opcode, bytes 1–5 are operands.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_execute`  in  1  one enqueue per cycle while high. Driven by the register block's `execute`.
- `in_command`  in  CMD_W  command; valid when `in_execute` is high.
- `in_busy`  out  1  almost-full; drives the register block's `busy`.
- `tpu_execute`  out  1  one-cycle start pulse to the TPU.
- `tpu_command`  out  CMD_W  command for the TPU; stable from the pulse until the next issue.
- `tpu_busy`  in  1  TPU is executing.
- `level`  out  $clog2(DEPTH+1)  current entry count.
- `overflow`  out  1  sticky; a command was dropped.

## Operation
- **Storage:** circular buffer with read and write pointers of width $clog2(DEPTH) that wrap naturally. `level` is an explicit counter running 0..DEPTH.
- **Push:** occurs when `in_execute` is high and (`level` < DEPTH, or a pop happens in the same cycle).
  - If `in_execute` is high, `level` == DEPTH and there is no pop: the command is dropped, `overflow` is set to 1, and the buffer is unchanged.
- **Simultaneous push and pop:** `level` is unchanged, both pointers advance, and this is legal at full.
- **`in_busy`:** `in_busy` = (`level` ≥ DEPTH−1), decoded combinationally from the registered `level`.
  - The register stage samples `busy` one cycle before it raises `execute`. This threshold therefore guarantees no overflow from a compliant upstream.
- **Dispatch FSM states:** IDLE, SETTLE, WAIT.
  - IDLE: if `level` > 0 and `tpu_busy` == 0, then on the next edge: `tpu_command` ← head, `tpu_execute` ← 1, pop, go to SETTLE.
  - SETTLE: `tpu_execute` ← 0 and `tpu_busy` is ignored. The TPU registers execute in this cycle. Go to WAIT.
  - WAIT: when `tpu_busy` == 0, go to IDLE. While `tpu_busy` is high, stay in WAIT.
- **Ordering:** commands reach the TPU strictly in arrival order. Operand bytes are passed through untouched.

## Timing
- **Reset values:** `level` 0, pointers 0, state IDLE, `tpu_execute` 0, `tpu_command` 0, `overflow` 0, `in_busy` 0. Buffer storage is not reset.
- **Enqueue-to-issue latency:** a command written at edge E into an empty queue, with the FSM in IDLE and `tpu_busy` low, produces `tpu_execute` high in the cycle after edge E+1.
- **Issue spacing:** at least 3 cycles between `tpu_execute` pulses (IDLE→SETTLE→WAIT→IDLE). The spacing is longer while `tpu_busy` stays high.
- **`tpu_execute`:** registered, high for exactly one cycle per issued command. It is never high in two consecutive cycles.
- **`overflow`:** set at the edge following the dropped command; cleared only by `reset`.
- **Reset mid-operation:** queued commands are discarded. An in-flight TPU command is not aborted, but its completion is not awaited; after reset the FSM starts in IDLE.
- **`tpu_busy` high while in IDLE:** the FSM holds and does not issue.

## Structure
- The shared header already provides the TPU opcode constants and TRUE/FALSE. Add these to it:
  - `CMD_W`
  - the FSM state encodings, as localparams of the package: IDLE=2'd0, SETTLE=2'd1, WAIT=2'd2.
- Sub-module `tpu_command_fifo`: storage, pointers, `level`, push/pop and overflow logic.
- The top level holds the dispatch FSM and the output registers.

## Test plan
- **Single command:** reset, then pulse `in_execute` with `in_command`=48'h0000_0000_4101 while `tpu_busy`=0.
  - `tpu_execute` is high for exactly 1 cycle, 2 edges after the push; `tpu_command`=48'h0000_0000_4101; `level` returns to 0.
- **Fill and drain with DEPTH=8:** hold `tpu_busy`=1 and push 8 distinct commands 0x01..0x08 on back-to-back cycles.
  - `in_busy` rises when `level`=7; `level`=8; `overflow`=0.
  - Release `tpu_busy`: 8 pulses carry 0x01..0x08 in order, each at least 3 cycles apart.
- **Overflow:** with the queue full and `tpu_busy`=1, push 0xAA.
  - `overflow`=1, `level` stays 8, and 0xAA is never issued.
  - `overflow` stays 1 after draining, until `reset`.
- **Push and pop at full:** with `level`=8, force an issue cycle (drop `tpu_busy` in IDLE) coincident with `in_execute`.
  - `level` stays 8, `overflow`=0, and the new command is issued last.
- **Busy handshake:** issue a command, then hold `tpu_busy` high for 20 cycles starting in SETTLE.
  - No second `tpu_execute` occurs until 1 cycle after `tpu_busy` falls.
- **Async reset mid-burst:** with `level`=5, assert `reset` between clock edges.
  - All outputs reach their reset values immediately; after release, no stale command is issued.

Source files
------------

// File: rtl/tpu_command_queue_pkg.sv
// Shared TPU constants: opcodes, boolean helpers, command width and the
// dispatch FSM encodings used by the command queue.
package tpu_command_queue_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // TPU opcodes (byte 0 of a command)
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_CLEAR  = 8'h01;
  localparam logic [7:0] OP_CURSOR = 8'h02;
  localparam logic [7:0] OP_PUTC   = 8'h03;

  localparam int CMD_W = 48;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETTLE = SETTLE,
    ST_WAIT   = WAIT
  } dispatch_state_t;

endpackage

// File: rtl/tpu_command_queue_if.sv
// Handshake bundle between the I2C register stage, the command queue and
// the TPU. The queue uses the slave view; the environment uses master.
interface tpu_command_queue_if #(
  parameter int CMD_W = tpu_command_queue_pkg::CMD_W
);
  logic             in_execute;
  logic [CMD_W-1:0] in_command;
  logic             in_busy;
  logic             tpu_execute;
  logic [CMD_W-1:0] tpu_command;
  logic             tpu_busy;

  modport slave (
    input  in_execute, in_command, tpu_busy,
    output in_busy, tpu_execute, tpu_command
  );

  modport master (
    output in_execute, in_command, tpu_busy,
    input  in_busy, tpu_execute, tpu_command
  );
endinterface

// File: rtl/tpu_command_fifo.sv
// Circular command buffer with an explicit occupancy counter and a sticky
// overflow flag. A push at full is accepted only when a pop happens in the
// same cycle; otherwise the command is dropped.
module tpu_command_fifo #(
  parameter  int DEPTH = 8,
  parameter  int CMD_W = 48,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic [CMD_W-1:0] push_data,
  input  logic             pop,
  output logic [CMD_W-1:0] head,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  logic [CMD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push;

  assign full   = (level == FULL);
  assign pop_ok = pop && (level != '0);
  assign push   = push_req && (!full || pop_ok);
  assign head   = mem[rd_ptr];

  // Storage is not reset; only written entries are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_req && full && !pop_ok) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/tpu_command_queue.sv
// Command queue between the I2C register stage and the TPU: buffers
// commands and issues them one at a time with a registered execute pulse.
//
// state  | meaning
// IDLE   | waiting for a queued command and an idle TPU
// SETTLE | pulse just issued; TPU is latching it, tpu_busy not yet valid
// WAIT   | waiting for the TPU to drop tpu_busy
module tpu_command_queue
  import tpu_command_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int CMD_W = tpu_command_queue_pkg::CMD_W,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  tpu_command_queue_if.slave      bus,
  output logic [LVL_W-1:0]        level,
  output logic                    overflow
);

  localparam logic [LVL_W-1:0] ALMOST_FULL = LVL_W'(DEPTH - 1);

  dispatch_state_t  state;
  dispatch_state_t  state_nxt;
  logic             issue;
  logic [CMD_W-1:0] head;
  logic             tpu_execute_q;
  logic [CMD_W-1:0] tpu_command_q;

  tpu_command_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_req  (bus.in_execute),
    .push_data (bus.in_command),
    .pop       (issue),
    .head      (head),
    .level     (level),
    .overflow  (overflow)
  );

  // Upstream samples busy a cycle ahead, so flag one entry early.
  assign bus.in_busy     = (level >= ALMOST_FULL);
  assign bus.tpu_execute = tpu_execute_q;
  assign bus.tpu_command = tpu_command_q;

  // Dispatch state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and issue decode.
  always_comb begin
    state_nxt = state;
    issue     = FALSE;
    case (state)
      ST_IDLE: begin
        if ((level != '0) && !bus.tpu_busy) begin
          issue     = TRUE;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: state_nxt = ST_WAIT;
      ST_WAIT:   if (!bus.tpu_busy) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Registered TPU outputs; command holds until the next issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tpu_execute_q <= 1'b0;
      tpu_command_q <= '0;
    end else begin
      tpu_execute_q <= issue;
      if (issue) tpu_command_q <= head;
    end
  end

endmodule

// File: tb/tb_tpu_command_queue.sv
// Self-checking bench for tpu_command_queue: directed scenarios followed by
// randomized traffic, compared each cycle against a queue-based model.
module tb_tpu_command_queue;
  import tpu_command_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 48;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] level;
  logic       overflow;

  tpu_command_queue_if #(.CMD_W(W)) bus ();

  tpu_command_queue #(
    .DEPTH (DEPTH),
    .CMD_W (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: FIFO contents, sticky overflow, last issued command and
  // whether the TPU has been seen idle long enough after the last issue.
  logic [W-1:0] mq[$];
  logic         m_ovf;
  logic         m_exec;
  logic [W-1:0] m_cmd;
  bit           m_ready;
  int           m_since;

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_exec  = 1'b0;
    m_cmd   = '0;
    m_ready = 1'b1;
    m_since = 0;
  endtask

  task automatic check_outputs();
    check("tpu_execute", 64'(bus.tpu_execute), 64'(m_exec));
    check("tpu_command", 64'(bus.tpu_command), 64'(m_cmd));
    check("level",       64'(level), 64'(mq.size()));
    check("in_busy",     64'(bus.in_busy), 64'(mq.size() >= DEPTH - 1));
    check("overflow",    64'(overflow), 64'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic cycle(input logic ex, input logic [W-1:0] cmd, input logic busy);
    bit issue;
    bus.in_execute = ex;
    bus.in_command = cmd;
    bus.tpu_busy   = busy;
    @(posedge clk);
    issue = m_ready && (mq.size() > 0) && !busy;
    if (issue) begin
      m_cmd   = mq.pop_front();
      m_ready = 1'b0;
      m_since = 0;
    end else begin
      m_since++;
      // TPU busy is only meaningful from the second edge after an issue.
      if (m_since >= 2 && !busy) m_ready = 1'b1;
    end
    m_exec = issue;
    if (ex) begin
      if (mq.size() < DEPTH) mq.push_back(cmd);
      else m_ovf = 1'b1;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_cycles(input int n, input logic busy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, busy);
  endtask

  task automatic async_reset_check();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  logic [W-1:0] rcmd;
  logic         rex;
  logic         rbusy;

  initial begin
    reset          = 1'b1;
    bus.in_execute = 1'b0;
    bus.in_command = '0;
    bus.tpu_busy   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;

    // Single command: pulse two edges after the push, queue drains.
    cycle(1'b1, 48'h0000_0000_4101, 1'b0);
    idle_cycles(6, 1'b0);

    // Fill to full while TPU is busy.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, W'(i), 1'b1);
    idle_cycles(2, 1'b1);

    // Push coincident with a pop at full: accepted, level holds.
    cycle(1'b1, 48'h55, 1'b0);

    // Full again with TPU busy: 0xAA is dropped.
    cycle(1'b1, 48'hAA, 1'b1);
    idle_cycles(3, 1'b1);

    // Drain; overflow remains set.
    idle_cycles(40, 1'b0);

    // Busy handshake: long busy starting in SETTLE, second command waits.
    cycle(1'b1, 48'h0102_0304_0501, 1'b0);
    cycle(1'b1, 48'h0A0B_0C0D_0E02, 1'b0);
    idle_cycles(20, 1'b1);
    idle_cycles(8, 1'b0);

    // Async reset mid-burst with five entries queued.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(48'h100 + i), 1'b1);
    async_reset_check();
    idle_cycles(10, 1'b0);

    // Randomized traffic from a compliant upstream.
    for (int i = 0; i < 2000; i++) begin
      rex   = !bus.in_busy && ($urandom_range(0, 2) != 0);
      rbusy = ($urandom_range(0, 3) == 0);
      rcmd  = {16'($urandom), 32'($urandom)};
      cycle(rex, rcmd, rbusy);
    end

    // Randomized traffic ignoring in_busy, TPU mostly busy.
    for (int i = 0; i < 1000; i++) begin
      rex   = 1'($urandom_range(0, 1));
      rbusy = ($urandom_range(0, 4) != 0);
      rcmd  = {16'($urandom), 32'($urandom)};
      cycle(rex, rcmd, rbusy);
    end
    idle_cycles(60, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
